// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC sample transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_dac_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 10;
    localparam int CFG_W   = 4;

    // Frame bits [15:12]: channel, unused, gain, shutdown_n.
    localparam logic [CFG_W-1:0] DEFAULT_CFG = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT,
        LATCH
    } state_e;

    // Frame layout: config nibble, 10-bit sample, two pad bits.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CFG_W-1:0]  cfg,
        input logic [DATA_W-1:0] sample
    );
        return {cfg, sample, 2'b00};
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate timer: one-cycle tick every SAMPLE_DIV clocks while enabled.
// Latency: tick on the cycle the counter sits at SAMPLE_DIV-1; count restarts at 0.
// Backpressure: none; ticks are free-running and the consumer drops any it cannot take.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: held at zero while disabled, wraps on terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_dac_tx.sv
// Pulls one 10-bit sample per tick from the FIFO and ships it as a 16-bit mode-0 SPI frame plus LDAC pulse.
// Latency: read strobe tick+1, cs_n low tick+3 for 32*CLK_DIV cycles, then LDAC low for CLK_DIV cycles.
// Backpressure: none upstream; an empty FIFO at tick resends the last sample and pulses underrun.
module spi_dac_tx
    import spi_dac_pkg::*;
#(
    parameter int               CLK_DIV    = 4,
    parameter int               SAMPLE_DIV = 1000,
    parameter logic [CFG_W-1:0] CFG_BITS   = DEFAULT_CFG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              ldac_n,
    output logic              busy,
    output logic              underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic tick;

    state_e              state_q,       state_d;
    logic [DIV_W-1:0]    div_q,         div_d;
    logic [3:0]          bit_q,         bit_d;
    logic [FRAME_W-2:0]  shift_q,       shift_d;   // bits still to send after the one on mosi
    logic [DATA_W-1:0]   last_sample_q, last_sample_d;
    logic                rd_issued_q,   rd_issued_d;
    logic                fifo_rd_en_q,  fifo_rd_en_d;
    logic                sclk_q,        sclk_d;
    logic                mosi_q,        mosi_d;
    logic                cs_n_q,        cs_n_d;
    logic                ldac_n_q,      ldac_n_d;
    logic                busy_q,        busy_d;
    logic                underrun_q,    underrun_d;

    logic [FRAME_W-1:0]  frame_w;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .tick_o   (tick)
    );

    // Fresh FIFO word if a read went out this frame, otherwise repeat the last one.
    assign frame_w = build_frame(CFG_BITS, rd_issued_q ? fifo_data : last_sample_q);

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        last_sample_d = last_sample_q;
        rd_issued_d   = rd_issued_q;
        fifo_rd_en_d  = 1'b0;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        cs_n_d        = cs_n_q;
        ldac_n_d      = ldac_n_q;
        busy_d        = busy_q;
        underrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                    if (!fifo_empty) begin
                        fifo_rd_en_d = 1'b1;
                        rd_issued_d  = 1'b1;
                    end else begin
                        underrun_d  = 1'b1;
                        rd_issued_d = 1'b0;
                    end
                end
            end

            // FIFO registers the read word during this cycle.
            FETCH: begin
                state_d = CAPTURE;
            end

            CAPTURE: begin
                if (rd_issued_q) begin
                    last_sample_d = fifo_data;
                end
                mosi_d  = frame_w[FRAME_W-1];
                shift_d = frame_w[FRAME_W-2:0];
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                div_d   = '0;
                bit_d   = 4'd15;
                state_d = SHIFT;
            end

            SHIFT: begin
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of a high phase: next bit goes out as sclk falls.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            cs_n_d   = 1'b1;
                            ldac_n_d = 1'b0;
                            mosi_d   = 1'b0;
                            state_d  = LATCH;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            mosi_d  = shift_q[FRAME_W-2];
                            shift_d = {shift_q[FRAME_W-3:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            LATCH: begin
                if (div_q == DIV_MAX) begin
                    div_d    = '0;
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            last_sample_q <= '0;
            rd_issued_q   <= 1'b0;
            fifo_rd_en_q  <= 1'b0;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            cs_n_q        <= 1'b1;
            ldac_n_q      <= 1'b1;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            last_sample_q <= last_sample_d;
            rd_issued_q   <= rd_issued_d;
            fifo_rd_en_q  <= fifo_rd_en_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            cs_n_q        <= cs_n_d;
            ldac_n_q      <= ldac_n_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_cs_n   = cs_n_q;
    assign ldac_n     = ldac_n_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_spi_dac_tx.sv
`timescale 1ns/1ps
module tb_spi_dac_tx;

    localparam int CLK_DIV    = 2;
    localparam int SAMPLE_DIV = 80;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       enable     = 1'b0;
    logic [9:0] fifo_data  = '0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       ldac_n;
    logic       busy;
    logic       underrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    spi_dac_tx #(
        .CLK_DIV    (CLK_DIV),
        .SAMPLE_DIV (SAMPLE_DIV),
        .CFG_BITS   (4'b0011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .ldac_n     (ldac_n),
        .busy       (busy),
        .underrun   (underrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data and registered empty flag.
    logic [9:0] fifo_mem [0:63];
    int         fifo_wr = 0;
    int         fifo_rd = 0;

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_rd != fifo_wr) begin
            fifo_data  <= fifo_mem[fifo_rd];
            fifo_empty <= (fifo_rd + 1 == fifo_wr);
            fifo_rd    <= fifo_rd + 1;
        end else begin
            fifo_empty <= (fifo_rd == fifo_wr);
        end
    end

    // Scoreboard of expected frames.
    logic [15:0] exp_frames [$];

    task automatic fifo_push(input logic [9:0] v);
        fifo_mem[fifo_wr] = v;
        fifo_wr++;
    endtask

    task automatic push_sample(input logic [9:0] v);
        fifo_push(v);
        exp_frames.push_back({4'b0011, v, 2'b00});
    endtask

    // Monitor: observed frames and pulse widths, sampled on the falling edge.
    logic [15:0] obs_frames [$];
    int obs_cs_len [$], obs_cs_fall [$], obs_rise [$], obs_bits [$];
    int obs_ldac [$], obs_busy [$], rd_cycles [$], unr_cycles [$];
    logic        in_frame  = 1'b0;
    logic        prev_sclk = 1'b0;
    logic [15:0] sh        = '0;
    int bits = 0, cs_run = 0, cs_start = 0, first_rise = 0, ldac_run = 0, busy_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            bits      = 0;
            ldac_run  = 0;
            busy_run  = 0;
            prev_sclk = 1'b0;
        end else begin
            if (fifo_rd_en) rd_cycles.push_back(cyc);
            if (underrun)   unr_cycles.push_back(cyc);
            if (!spi_cs_n) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    cs_start   = cyc;
                    cs_run     = 0;
                    bits       = 0;
                    sh         = '0;
                    first_rise = -1;
                end
                cs_run++;
                if (spi_sclk && !prev_sclk) begin
                    sh = {sh[14:0], spi_mosi};
                    if (bits == 0) first_rise = cyc;
                    bits++;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                obs_frames.push_back(sh);
                obs_cs_len.push_back(cs_run);
                obs_cs_fall.push_back(cs_start);
                obs_rise.push_back(first_rise);
                obs_bits.push_back(bits);
            end
            if (!ldac_n) ldac_run++;
            else if (ldac_run > 0) begin
                obs_ldac.push_back(ldac_run);
                ldac_run = 0;
            end
            if (busy) busy_run++;
            else if (busy_run > 0) begin
                obs_busy.push_back(busy_run);
                busy_run = 0;
            end
            prev_sclk = spi_sclk;
        end
    end

    task automatic wait_for(input int nfr, input int nld, input int budget);
        int i = 0;
        while ((obs_frames.size() < nfr || obs_ldac.size() < nld) && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en); end
        n_cmp++; if (spi_sclk   !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b expected 0", spi_sclk); end
        n_cmp++; if (spi_mosi   !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b expected 0", spi_mosi); end
        n_cmp++; if (spi_cs_n   !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b expected 1", spi_cs_n); end
        n_cmp++; if (ldac_n     !== 1'b1) begin n_fail++; $display("FAIL rst_ldac_n: got %b expected 1", ldac_n); end
        n_cmp++; if (busy       !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (underrun   !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2 * SAMPLE_DIV) @(posedge clk);
        #1;
        n_cmp++; if (rd_cycles.size() != 0 || obs_frames.size() != 0) begin
            n_fail++; $display("FAIL disabled_idle: got %0d reads %0d frames expected 0 0", rd_cycles.size(), obs_frames.size());
        end
    endtask

    task automatic test_single_frame();
        int f0 = obs_frames.size();
        int l0 = obs_ldac.size();
        int r0 = rd_cycles.size();
        int b0 = obs_busy.size();
        int e0;
        logic [15:0] exp;
        push_sample(10'h2A5);
        @(posedge clk); #1;
        enable = 1'b1;
        e0 = cyc;
        wait_for(f0 + 1, l0 + 1, 400);
        enable = 1'b0;
        n_cmp++; if (obs_frames.size() < f0 + 1 || obs_ldac.size() < l0 + 1) begin
            n_fail++; $display("FAIL single_timeout: got %0d frames expected %0d", obs_frames.size() - f0, 1);
        end else begin
            exp = exp_frames.pop_front();
            n_cmp++; if (obs_frames[f0] !== exp) begin n_fail++; $display("FAIL single_frame: got %h expected %h", obs_frames[f0], exp); end
            n_cmp++; if (rd_cycles.size() - r0 != 1) begin n_fail++; $display("FAIL single_rd_count: got %0d expected 1", rd_cycles.size() - r0); end
            n_cmp++; if (rd_cycles.size() <= r0 || rd_cycles[r0] != e0 + SAMPLE_DIV) begin
                n_fail++; $display("FAIL single_rd_cycle: got %0d expected %0d", (rd_cycles.size() > r0) ? rd_cycles[r0] - e0 : -1, SAMPLE_DIV);
            end
            n_cmp++; if (obs_bits[f0] != 16) begin n_fail++; $display("FAIL single_sclk_rises: got %0d expected 16", obs_bits[f0]); end
            n_cmp++; if (obs_cs_len[f0] != 32 * CLK_DIV) begin n_fail++; $display("FAIL single_cs_len: got %0d expected %0d", obs_cs_len[f0], 32 * CLK_DIV); end
            n_cmp++; if (obs_ldac[l0] != CLK_DIV) begin n_fail++; $display("FAIL single_ldac_len: got %0d expected %0d", obs_ldac[l0], CLK_DIV); end
            n_cmp++; if (rd_cycles.size() <= r0 || obs_cs_fall[f0] != rd_cycles[r0] + 2) begin
                n_fail++; $display("FAIL single_cs_fall: got %0d expected %0d", obs_cs_fall[f0] - e0, SAMPLE_DIV + 2);
            end
            n_cmp++; if (obs_rise[f0] != obs_cs_fall[f0] + CLK_DIV) begin
                n_fail++; $display("FAIL single_first_rise: got %0d expected %0d", obs_rise[f0] - obs_cs_fall[f0], CLK_DIV);
            end
            n_cmp++; if (obs_busy.size() <= b0 || obs_busy[b0] != 2 + 33 * CLK_DIV) begin
                n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", (obs_busy.size() > b0) ? obs_busy[b0] : -1, 2 + 33 * CLK_DIV);
            end
        end
    endtask

    task automatic test_underrun();
        int f0 = obs_frames.size();
        int l0 = obs_ldac.size();
        int r0 = rd_cycles.size();
        int u0 = unr_cycles.size();
        logic [15:0] exp;
        push_sample(10'h3FF);
        exp_frames.push_back(16'h3FFC);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_for(f0 + 2, l0 + 2, 500);
        enable = 1'b0;
        n_cmp++; if (obs_frames.size() < f0 + 2) begin
            n_fail++; $display("FAIL underrun_timeout: got %0d frames expected 2", obs_frames.size() - f0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp = exp_frames.pop_front();
                n_cmp++; if (obs_frames[f0 + k] !== exp) begin n_fail++; $display("FAIL underrun_frame%0d: got %h expected %h", k, obs_frames[f0 + k], exp); end
            end
            n_cmp++; if (rd_cycles.size() - r0 != 1) begin n_fail++; $display("FAIL underrun_rd_count: got %0d expected 1", rd_cycles.size() - r0); end
            n_cmp++; if (unr_cycles.size() - u0 != 1) begin n_fail++; $display("FAIL underrun_pulses: got %0d expected 1", unr_cycles.size() - u0); end
            n_cmp++; if (unr_cycles.size() <= u0 || unr_cycles[u0] != obs_cs_fall[f0 + 1] - 2) begin
                n_fail++; $display("FAIL underrun_cycle: got %0d expected %0d", (unr_cycles.size() > u0) ? unr_cycles[u0] : -1, obs_cs_fall[f0 + 1] - 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0 = obs_frames.size();
        int l0 = obs_ldac.size();
        int r0 = rd_cycles.size();
        logic [15:0] exp;
        push_sample(10'h000);
        push_sample(10'h155);
        push_sample(10'h3FF);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_for(f0 + 3, l0 + 3, 700);
        enable = 1'b0;
        n_cmp++; if (obs_frames.size() < f0 + 3) begin
            n_fail++; $display("FAIL b2b_timeout: got %0d frames expected 3", obs_frames.size() - f0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp = exp_frames.pop_front();
                n_cmp++; if (obs_frames[f0 + k] !== exp) begin n_fail++; $display("FAIL b2b_frame%0d: got %h expected %h", k, obs_frames[f0 + k], exp); end
            end
            for (int k = 1; k < 3; k++) begin
                n_cmp++; if (obs_cs_fall[f0 + k] - obs_cs_fall[f0 + k - 1] != SAMPLE_DIV) begin
                    n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, obs_cs_fall[f0 + k] - obs_cs_fall[f0 + k - 1], SAMPLE_DIV);
                end
            end
            n_cmp++; if (rd_cycles.size() - r0 != 3) begin n_fail++; $display("FAIL b2b_rd_count: got %0d expected 3", rd_cycles.size() - r0); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int i = 0;
        int f0, l0, r0, c0;
        logic [15:0] exp;
        fifo_push(10'h0AA);              // consumed by the aborted frame
        push_sample(10'h1C3);
        @(posedge clk); #1;
        enable = 1'b1;
        while (!(in_frame && bits >= 9) && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        n_cmp++; if (i >= 400) begin n_fail++; $display("FAIL rstmid_reach_bit7: got timeout expected bit 7 reached"); end
        l0 = obs_ldac.size();
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_n: got %b expected 1", spi_cs_n); end
        n_cmp++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk: got %b expected 0", spi_sclk); end
        n_cmp++; if (ldac_n   !== 1'b1) begin n_fail++; $display("FAIL rstmid_ldac_n: got %b expected 1", ldac_n); end
        n_cmp++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        r0 = rd_cycles.size();
        f0 = obs_frames.size();
        n_cmp++; if (obs_ldac.size() != l0) begin n_fail++; $display("FAIL rstmid_no_ldac: got %0d pulses expected 0", obs_ldac.size() - l0); end
        wait_for(f0 + 1, l0 + 1, 400);
        enable = 1'b0;
        n_cmp++; if (obs_frames.size() < f0 + 1) begin
            n_fail++; $display("FAIL rstmid_timeout: got %0d frames expected 1", obs_frames.size() - f0);
        end else begin
            exp = exp_frames.pop_front();
            n_cmp++; if (obs_frames[f0] !== exp) begin n_fail++; $display("FAIL rstmid_frame: got %h expected %h", obs_frames[f0], exp); end
            n_cmp++; if (rd_cycles.size() <= r0 || rd_cycles[r0] != c0 + SAMPLE_DIV) begin
                n_fail++; $display("FAIL rstmid_restart: got %0d expected %0d", (rd_cycles.size() > r0) ? rd_cycles[r0] - c0 : -1, SAMPLE_DIV);
            end
        end
    endtask

    task automatic test_enable_mid_frame();
        int i = 0;
        int f0 = obs_frames.size();
        int l0 = obs_ldac.size();
        int r0 = rd_cycles.size();
        logic [15:0] exp;
        push_sample(10'h111);
        push_sample(10'h222);
        @(posedge clk); #1;
        enable = 1'b1;
        while (!in_frame && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        enable = 1'b0;
        n_cmp++; if (i >= 400) begin n_fail++; $display("FAIL en_reach_frame: got timeout expected frame start"); end
        wait_for(f0 + 1, l0 + 1, 400);
        n_cmp++; if (obs_frames.size() < f0 + 1 || obs_ldac.size() < l0 + 1) begin
            n_fail++; $display("FAIL en_complete: got %0d frames expected 1", obs_frames.size() - f0);
        end else begin
            exp = exp_frames.pop_front();
            n_cmp++; if (obs_frames[f0] !== exp) begin n_fail++; $display("FAIL en_frame0: got %h expected %h", obs_frames[f0], exp); end
            n_cmp++; if (obs_ldac[l0] != CLK_DIV) begin n_fail++; $display("FAIL en_ldac_len: got %0d expected %0d", obs_ldac[l0], CLK_DIV); end
        end
        repeat (3 * SAMPLE_DIV) @(posedge clk);
        #1;
        n_cmp++; if (rd_cycles.size() - r0 != 1) begin n_fail++; $display("FAIL en_no_reads: got %0d reads expected 1", rd_cycles.size() - r0); end
        enable = 1'b1;
        wait_for(f0 + 2, l0 + 2, 400);
        enable = 1'b0;
        n_cmp++; if (obs_frames.size() < f0 + 2) begin
            n_fail++; $display("FAIL en_resume_timeout: got %0d frames expected 2", obs_frames.size() - f0);
        end else begin
            exp = exp_frames.pop_front();
            n_cmp++; if (obs_frames[f0 + 1] !== exp) begin n_fail++; $display("FAIL en_frame1: got %h expected %h", obs_frames[f0 + 1], exp); end
            n_cmp++; if (rd_cycles.size() - r0 != 2) begin n_fail++; $display("FAIL en_resume_reads: got %0d expected 2", rd_cycles.size() - r0); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_underrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_mid_frame();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
